// File: rtl/ternary_mm_sequencer_if.sv
// Host/array/sequencer bundle for the ternary matrix-multiply array.
// master: host + array side; slave: the sequencer.
interface ternary_mm_sequencer_if #(
  parameter int KW = 8
);
  logic          start;
  logic [KW-1:0] k_len;
  logic [3:0]    shift;
  logic          relu;
  logic          in_valid;
  logic          in_ready;
  logic          array_en;
  logic          clear_acc;
  logic          copy_out;
  logic          restart_q;
  logic [3:0]    out_index;
  logic [16:0]   acc_in;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport master (
    output start, k_len, shift, relu,
    output in_valid, out_ready, acc_in,
    input  in_ready, array_en, clear_acc,
    input  copy_out, restart_q, out_index,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  start, k_len, shift, relu,
    input  in_valid, out_ready, acc_in,
    output in_ready, array_en, clear_acc,
    output copy_out, restart_q, out_index,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/ternary_mm_sequencer.sv
// Job sequencer for the ternary MM array: clear, accumulate K*SLICES beats,
// snapshot, then stream NOUT results through shift/ReLU/int8 saturation.
// Ports: clk, reset (sync, active-high), bus (slave side of the bundle).
module ternary_mm_sequencer #(
  parameter int SLICES = 2,
  parameter int NOUT   = 16,
  parameter int KW     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ternary_mm_sequencer_if.slave bus
);
  // Beat counter must hold k_len*SLICES.
  localparam int CW =
    (SLICES > 2) ? KW + $clog2(SLICES) : KW + 1;
  localparam logic [3:0] LAST = 4'(NOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_COPY,
    S_READ,
    S_DONE
  } state_t;

  state_t state;
  state_t next;

  logic [KW-1:0] k_lat;
  logic [3:0]    shift_lat;
  logic          relu_lat;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_tgt;
  logic [3:0]    idx;
  logic          last_beat;

  logic in_ready;
  logic array_en;
  logic clear_acc;
  logic copy_out;
  logic restart_q;
  logic out_valid;
  logic done;

  logic signed [16:0] shifted;
  logic signed [16:0] clamped;
  logic [7:0]         sat;

  assign beat_tgt  = CW'(k_lat) * CW'(SLICES);
  assign last_beat = (beat_cnt + CW'(1)) == beat_tgt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    array_en  = 1'b0;
    clear_acc = 1'b0;
    copy_out  = 1'b0;
    restart_q = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) next = S_CLEAR;
      end
      S_CLEAR: begin
        clear_acc = 1'b1;
        next = (k_lat == '0) ? S_COPY : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        array_en = bus.in_valid;
        if (bus.in_valid && last_beat) next = S_COPY;
      end
      S_COPY: begin
        copy_out  = 1'b1;
        restart_q = 1'b1;
        next      = S_READ;
      end
      S_READ: begin
        out_valid = 1'b1;
        if (bus.out_ready && idx == LAST) next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_lat     <= '0;
      shift_lat <= '0;
      relu_lat  <= 1'b0;
      beat_cnt  <= '0;
      idx       <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        k_lat     <= bus.k_len;
        shift_lat <= bus.shift;
        relu_lat  <= bus.relu;
        beat_cnt  <= '0;
      end else if (array_en) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
      if (state == S_COPY) begin
        idx <= '0;
      end else if (out_valid && bus.out_ready) begin
        idx <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    shifted = $signed(bus.acc_in) >>> shift_lat;
    clamped = shifted;
    if (relu_lat && shifted[16]) clamped = '0;
    sat = clamped[7:0];
    if (clamped > 17'sd127) begin
      sat = 8'h7f;
    end else if (clamped < -17'sd128) begin
      sat = 8'h80;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.array_en  = array_en;
  assign bus.clear_acc = clear_acc;
  assign bus.copy_out  = copy_out;
  assign bus.restart_q = restart_q;
  assign bus.out_index = idx;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? sat : 8'h00;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done;
endmodule
